// File: rtl/deintlv_pkg.sv
// -----------------------------------------------------------------------------
// deintlv_pkg
// Shared definitions for the block deinterleaver:
//   - default matrix geometry (DEF_ROWS x DEF_COLS) and derived block size
//   - counter-width helper used for the bank address / row / column counters
//   - write-side and read-side FSM state encodings
// Ports: none (package).
// -----------------------------------------------------------------------------
package deintlv_pkg;

    localparam int DEF_ROWS  = 4;
    localparam int DEF_COLS  = 8;
    localparam int DEF_N     = DEF_ROWS * DEF_COLS;
    localparam int DEF_CNT_W = $clog2(DEF_N);

    // Width of a counter spanning 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    typedef enum logic {
        W_FILL = 1'b0,
        W_WAIT = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } r_state_t;

endpackage

// File: rtl/deintlv_bank.sv
// -----------------------------------------------------------------------------
// deintlv_bank
// One storage bank of the ping-pong deinterleaver: N single-bit flops, each
// loaded only when the write enable is set and the write address selects it.
// The read port is a purely combinational address mux.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset (clears contents)
//   i_we     - write enable
//   i_waddr  - write address (0..N-1)
//   i_wdata  - write data bit
//   i_raddr  - read address (0..N-1)
//   o_rdata  - bit stored at i_raddr
// -----------------------------------------------------------------------------
module deintlv_bank #(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic          i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic          o_rdata
);

    logic [N-1:0] r_mem;

    // Bit storage: only the addressed flop loads on a write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i_we && (i_waddr == AW'(i))) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    // Read mux; addresses past the end (non power-of-two N) return 0.
    always_comb begin
        o_rdata = 1'b0;
        if (int'(i_raddr) < N) begin
            o_rdata = r_mem[i_raddr];
        end else begin
            o_rdata = 1'b0;
        end
    end

endmodule

// File: rtl/block_deinterleaver.sv
// -----------------------------------------------------------------------------
// block_deinterleaver
// Serial-bit block deinterleaver undoing a ROWS x COLS row-write/column-read
// interleaver. Incoming bit k of a block is stored at bank address k; output
// position j = r*COLS + c is read from bank address c*ROWS + r. Two banks
// are used ping-pong: the write side fills one while the read side drains the
// other. A bank's last write and the other bank's last read may land on the
// same edge; both sides then swap together with no bubble.
//
// Optional feature: define DEINTLV_SOF_EN to add output dout_sof, high with
// dout_valid on output position 0 of every block.
//
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   din        - interleaved serial input bit
//   din_valid  - din is valid
//   din_ready  - block accepts din (registered)
//   dout       - deinterleaved serial output bit (registered)
//   dout_valid - dout is valid (registered, high exactly while draining)
//   dout_ready - downstream accepts dout
//   dout_sof   - (DEINTLV_SOF_EN only) first bit of a block
// -----------------------------------------------------------------------------
module block_deinterleaver
    import deintlv_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    input  logic din_valid,
    output logic din_ready,
    output logic dout,
    output logic dout_valid,
    input  logic dout_ready
`ifdef DEINTLV_SOF_EN
    ,
    output logic dout_sof
`endif
);

    localparam int N     = ROWS * COLS;
    localparam int CNT_W = cnt_width(N);
    localparam int ROW_W = cnt_width(ROWS);
    localparam int COL_W = cnt_width(COLS);

    localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] ROWS_C     = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [COL_W-1:0] COL_LAST_C = COL_W'(COLS - 1);

    // Write side
    w_state_t           r_wstate;
    w_state_t           w_wstate_nxt;
    logic               r_wsel;
    logic               w_wsel_nxt;
    logic [CNT_W-1:0]   r_wcnt;
    logic [CNT_W-1:0]   w_wcnt_nxt;
    logic               r_din_ready;

    // Read side
    r_state_t           r_rstate;
    r_state_t           w_rstate_nxt;
    logic               r_rsel;
    logic               w_rsel_nxt;
    logic [CNT_W-1:0]   r_rcnt;
    logic [CNT_W-1:0]   w_rcnt_nxt;
    logic [CNT_W-1:0]   r_raddr;
    logic [CNT_W-1:0]   w_raddr_nxt;
    logic [ROW_W-1:0]   r_rrow;
    logic [ROW_W-1:0]   w_rrow_nxt;
    logic [COL_W-1:0]   r_rcol;
    logic [COL_W-1:0]   w_rcol_nxt;

    // Shared
    logic [1:0]         r_full;
    logic [1:0]         w_full_nxt;
    logic [1:0]         w_bank_we;
    logic [1:0]         w_bank_rd;
    logic               r_dout;
    logic               w_dout_nxt;
    logic               r_dout_valid;
    logic               r_dout_sof;
    logic               w_dout_sof_nxt;

    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_wdone;
    logic               w_rdone;

    assign w_in_xfer  = din_valid & r_din_ready;
    assign w_out_xfer = r_dout_valid & dout_ready;
    assign w_wdone    = w_in_xfer & (r_wcnt == LAST_C);
    assign w_rdone    = w_out_xfer & (r_rcnt == LAST_C);

    assign w_bank_we[0] = w_in_xfer & (r_wsel == 1'b0);
    assign w_bank_we[1] = w_in_xfer & (r_wsel == 1'b1);

    // Both banks share the read address; the selected one feeds dout.
    deintlv_bank #(.N(N), .AW(CNT_W)) u_bank0 (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_we    (w_bank_we[0]),
        .i_waddr (r_wcnt),
        .i_wdata (din),
        .i_raddr (w_raddr_nxt),
        .o_rdata (w_bank_rd[0])
    );

    deintlv_bank #(.N(N), .AW(CNT_W)) u_bank1 (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_we    (w_bank_we[1]),
        .i_waddr (r_wcnt),
        .i_wdata (din),
        .i_raddr (w_raddr_nxt),
        .o_rdata (w_bank_rd[1])
    );

    // Write FSM next state: fill a bank, then swap or wait for the other bank.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wsel_nxt   = r_wsel;
        w_wcnt_nxt   = r_wcnt;
        case (r_wstate)
            W_FILL: begin
                if (w_in_xfer) begin
                    if (w_wdone) begin
                        w_wcnt_nxt = '0;
                        // Other bank still holds data unless it finishes draining now.
                        if (r_full[~r_wsel] && !(w_rdone && (r_rsel != r_wsel))) begin
                            w_wstate_nxt = W_WAIT;
                        end else begin
                            w_wsel_nxt = ~r_wsel;
                        end
                    end else begin
                        w_wcnt_nxt = r_wcnt + ONE_C;
                    end
                end else begin
                    w_wcnt_nxt = r_wcnt;
                end
            end
            W_WAIT: begin
                if (w_rdone) begin
                    w_wstate_nxt = W_FILL;
                    w_wsel_nxt   = ~r_wsel;
                end else begin
                    w_wstate_nxt = W_WAIT;
                end
            end
            default: begin
                w_wstate_nxt = W_FILL;
                w_wsel_nxt   = 1'b0;
                w_wcnt_nxt   = '0;
            end
        endcase
    end

    // Read FSM next state: drain in column-major address order.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rsel_nxt   = r_rsel;
        w_rcnt_nxt   = r_rcnt;
        w_raddr_nxt  = r_raddr;
        w_rrow_nxt   = r_rrow;
        w_rcol_nxt   = r_rcol;
        case (r_rstate)
            R_IDLE: begin
                // Banks complete in the same order they are drained, so the
                // next bank to read is always r_rsel.
                if (r_full[r_rsel]) begin
                    w_rstate_nxt = R_DRAIN;
                end else begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            R_DRAIN: begin
                if (w_out_xfer) begin
                    if (w_rdone) begin
                        w_rsel_nxt  = ~r_rsel;
                        w_rcnt_nxt  = '0;
                        w_raddr_nxt = '0;
                        w_rrow_nxt  = '0;
                        w_rcol_nxt  = '0;
                        // Continue without a bubble if the other bank is full
                        // or completes on this very edge (address 0 is long written).
                        if (r_full[~r_rsel] || (w_wdone && (r_wsel != r_rsel))) begin
                            w_rstate_nxt = R_DRAIN;
                        end else begin
                            w_rstate_nxt = R_IDLE;
                        end
                    end else begin
                        w_rcnt_nxt = r_rcnt + ONE_C;
                        if (r_rcol == COL_LAST_C) begin
                            w_rcol_nxt  = '0;
                            w_rrow_nxt  = r_rrow + ROW_W'(1);
                            w_raddr_nxt = CNT_W'(r_rrow) + ONE_C;
                        end else begin
                            w_rcol_nxt  = r_rcol + COL_W'(1);
                            w_raddr_nxt = r_raddr + ROWS_C;
                        end
                    end
                end else begin
                    w_rstate_nxt = R_DRAIN;
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
                w_rsel_nxt   = 1'b0;
                w_rcnt_nxt   = '0;
                w_raddr_nxt  = '0;
                w_rrow_nxt   = '0;
                w_rcol_nxt   = '0;
            end
        endcase
    end

    // Bank-full flags plus next output bit and start-of-block marker.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wdone) begin
            w_full_nxt[r_wsel] = 1'b1;
        end else begin
            w_full_nxt[r_wsel] = r_full[r_wsel];
        end
        if (w_rdone) begin
            w_full_nxt[r_rsel] = 1'b0;
        end else begin
            w_full_nxt[r_rsel] = w_full_nxt[r_rsel];
        end
        if (w_rstate_nxt == R_DRAIN) begin
            w_dout_nxt     = w_bank_rd[w_rsel_nxt];
            w_dout_sof_nxt = (w_rcnt_nxt == '0);
        end else begin
            w_dout_nxt     = 1'b0;
            w_dout_sof_nxt = 1'b0;
        end
    end

    // Write-side state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wstate    <= W_FILL;
            r_wsel      <= 1'b0;
            r_wcnt      <= '0;
            r_din_ready <= 1'b0;
        end else begin
            r_wstate    <= w_wstate_nxt;
            r_wsel      <= w_wsel_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_din_ready <= (w_wstate_nxt == W_FILL);
        end
    end

    // Read-side state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rstate <= R_IDLE;
            r_rsel   <= 1'b0;
            r_rcnt   <= '0;
            r_raddr  <= '0;
            r_rrow   <= '0;
            r_rcol   <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_rsel   <= w_rsel_nxt;
            r_rcnt   <= w_rcnt_nxt;
            r_raddr  <= w_raddr_nxt;
            r_rrow   <= w_rrow_nxt;
            r_rcol   <= w_rcol_nxt;
        end
    end

    // Bank flags and registered output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full       <= 2'b00;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_sof   <= 1'b0;
        end else begin
            r_full       <= w_full_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= (w_rstate_nxt == R_DRAIN);
            r_dout_sof   <= w_dout_sof_nxt;
        end
    end

    assign din_ready  = r_din_ready;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

`ifdef DEINTLV_SOF_EN
    assign dout_sof = r_dout_sof;
`else
    logic w_sof_unused;
    assign w_sof_unused = r_dout_sof;
`endif

endmodule

// File: tb/tb_block_deinterleaver.sv
// -----------------------------------------------------------------------------
// tb_block_deinterleaver
// Scoreboard bench: each block issued pushes its expected output bits (and
// start-of-block flag) into a queue; a monitor pops and compares on every
// output transfer and also checks that dout/dout_valid hold while stalled.
// -----------------------------------------------------------------------------
module tb_block_deinterleaver;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int N    = ROWS * COLS;

    logic clk = 1'b0;
    logic reset_n;
    logic din;
    logic din_valid;
    logic din_ready;
    logic dout;
    logic dout_valid;
    logic dout_ready;
`ifdef DEINTLV_SOF_EN
    logic dout_sof;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0] exp_q[$];

    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_dout  = 1'b0;

    always #5 clk = ~clk;

    block_deinterleaver #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef DEINTLV_SOF_EN
        ,
        .dout_sof   (dout_sof)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference row-write/column-read interleaver.
    function automatic logic [31:0] interleave(input logic [31:0] orig);
        logic [31:0] s;
        s = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                s[c*ROWS + r] = orig[r*COLS + c];
            end
        end
        return s;
    endfunction

    task automatic push_block(input logic [31:0] exp_bits);
        for (int j = 0; j < N; j++) begin
            exp_q.push_back({(j == 0) ? 1'b1 : 1'b0, exp_bits[j]});
        end
    endtask

    // Offers nbits of stream (LSB first); call at posedge+1, returns at posedge+1.
    task automatic send_block(input logic [31:0] stream, input int nbits, input bit keep_valid);
        bit acc;
        for (int i = 0; i < nbits; i++) begin
            din       = stream[i];
            din_valid = 1'b1;
            acc       = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = din_ready;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: bit %0d not accepted, din_ready=%0b expected 1", i, din_ready);
            end
        end
        if (!keep_valid) begin
            din_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_dout_valid", dout_valid, 1'b0);
    endtask

    // Monitor: compares every output transfer against the scoreboard.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!reset_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_dout  = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", dout_valid, 1'b1);
                check("hold_dout", dout, prev_dout);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got dout=%0b, expected no output", dout);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", dout, e[0]);
`ifdef DEINTLV_SOF_EN
                    check("dout_sof", dout_sof, e[1]);
`endif
                end
            end
            prev_valid = dout_valid;
            prev_ready = dout_ready;
            prev_dout  = dout;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] orig;
        reset_n    = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_din_ready", din_ready, 1'b0);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_dout", dout, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("din_ready_after_rst", din_ready, 1'b1);

        // Impulse at stream bit 1 -> output position 8 only
        push_block(32'h0000_0100);
        send_block(32'h0000_0002, N, 1'b0);
        check("latency_pre", dout_valid, 1'b0);
        @(posedge clk);
        #1;
        check("latency_first_valid", dout_valid, 1'b1);
        wait_drain();

        // Round trip through the interleaver model
        orig = 32'hA5C3_0F96;
        push_block(orig);
        send_block(interleave(orig), N, 1'b0);
        wait_drain();

        // Backpressure: 64 bits offered while dout_ready is low for 40 cycles
        push_block(32'h3C5A_96E1);
        push_block(32'h8421_7BDE);
        fork
            begin
                send_block(interleave(32'h3C5A_96E1), N, 1'b1);
                send_block(interleave(32'h8421_7BDE), N, 1'b0);
                check("bp_din_ready_drop", din_ready, 1'b0);
            end
            begin
                dout_ready = 1'b0;
                repeat (40) @(posedge clk);
                #1;
                dout_ready = 1'b1;
            end
        join
        wait_drain();

        // Back-to-back: three blocks with continuous valid/ready
        push_block(32'h1234_5678);
        push_block(32'hDEAD_BEEF);
        push_block(32'h0F0F_33CC);
        fork
            begin
                send_block(interleave(32'h1234_5678), N, 1'b1);
                send_block(interleave(32'hDEAD_BEEF), N, 1'b1);
                send_block(interleave(32'h0F0F_33CC), N, 1'b0);
            end
            begin
                int run;
                bit seen;
                seen = 1'b0;
                run  = 0;
                for (int t = 0; t < 100 && !seen; t++) begin
                    @(negedge clk);
                    seen = dout_valid;
                end
                if (seen) begin
                    run = 1;
                    while (run < 200) begin
                        @(negedge clk);
                        if (!dout_valid) begin
                            break;
                        end
                        run++;
                    end
                end
                check("b2b_valid_run", run, 96);
            end
        join
        wait_drain();

        // Reset after 20 bits, then a fresh block
        send_block(32'hFFFF_FFFF, 20, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_din_ready", din_ready, 1'b0);
        check("midrst_dout_valid", dout_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_din_ready_after", din_ready, 1'b1);
        orig = 32'h6B1E_D407;
        push_block(orig);
        send_block(interleave(orig), N, 1'b0);
        wait_drain();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
